// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types and default bit timing for the UART
package uart_pkg;
    localparam int CLKS_PER_BIT_DEFAULT = 434;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer resetting to the idle-high line level
module uart_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] ff;
    always_ff @(posedge clock or posedge reset)
        if (reset) ff <= 2'b11;
        else       ff <= {ff[0], d};
    assign q = ff[1];
endmodule

// File: rtl/uart.sv
// uart: 8N1 transmitter and receiver running independently off one clock
module uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       UART_RX,
    output logic       UART_TX,
    output logic       rx_complete,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_complete
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);

    tx_state_t tx_state, tx_next;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0] tx_idx, tx_idx_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic tx_line_n, tx_done_n;
    logic tx_end;
    assign tx_end = tx_cnt == LAST;

    // ones shift in behind the data so the line is already high for the stop bit
    always_comb begin
        tx_next = tx_state;
        tx_cnt_n = tx_cnt + 1'b1;
        tx_idx_n = tx_idx;
        tx_shift_n = tx_shift;
        tx_line_n = UART_TX;
        tx_done_n = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_valid) begin
                    tx_next = TX_START;
                    tx_shift_n = tx_data;
                    tx_line_n = 1'b0;
                end
            end
            TX_START: if (tx_end) begin
                tx_next = TX_DATA;
                tx_cnt_n = '0;
                tx_line_n = tx_shift[0];
            end
            TX_DATA: if (tx_end) begin
                tx_cnt_n = '0;
                tx_idx_n = tx_idx + 3'd1;
                tx_shift_n = {1'b1, tx_shift[7:1]};
                tx_line_n = tx_shift[1];
                tx_next = tx_idx == 3'd7 ? TX_STOP : TX_DATA;
            end
            TX_STOP: if (tx_end) begin
                tx_next = TX_DONE;
                tx_cnt_n = '0;
                tx_done_n = 1'b1;
            end
            TX_DONE: begin
                tx_next = TX_IDLE;
                tx_cnt_n = '0;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_shift <= '0;
            UART_TX <= 1'b1;
            tx_complete <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_cnt <= tx_cnt_n;
            tx_idx <= tx_idx_n;
            tx_shift <= tx_shift_n;
            UART_TX <= tx_line_n;
            tx_complete <= tx_done_n;
        end

    logic rxs;
    uart_sync2 u_sync (.clock(clock), .reset(reset), .d(UART_RX), .q(rxs));

    rx_state_t rx_state, rx_next;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_idx, rx_idx_n;
    logic [7:0] rx_shift, rx_shift_n, rx_data_n;
    logic rx_done_n;
    logic rx_end;
    assign rx_end = rx_cnt == LAST;

    always_comb begin
        rx_next = rx_state;
        rx_cnt_n = rx_cnt + 1'b1;
        rx_idx_n = rx_idx;
        rx_shift_n = rx_shift;
        rx_data_n = rx_data;
        rx_done_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                rx_next = rxs ? RX_IDLE : RX_START;
            end
            RX_START: if (rx_cnt == MID) begin
                rx_cnt_n = '0;
                rx_next = rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_end) begin
                rx_cnt_n = '0;
                rx_shift_n = {rxs, rx_shift[7:1]};
                rx_idx_n = rx_idx + 3'd1;
                rx_next = rx_idx == 3'd7 ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (rx_end) begin
                rx_cnt_n = '0;
                rx_next = rxs ? RX_IDLE : RX_WAIT_HIGH;
                rx_done_n = rxs;
                rx_data_n = rxs ? rx_shift : rx_data;
            end
            RX_WAIT_HIGH: begin
                rx_cnt_n = '0;
                rx_next = rxs ? RX_IDLE : RX_WAIT_HIGH;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_shift <= '0;
            rx_data <= 8'h00;
            rx_complete <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_cnt <= rx_cnt_n;
            rx_idx <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_data <= rx_data_n;
            rx_complete <= rx_done_n;
        end
endmodule

// File: tb/tb_uart.sv
// tb_uart: randomized 8N1 frames checked against a timing-table model of the line
module tb_uart;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic UART_RX = 1'b1;
    logic UART_TX;
    logic rx_complete;
    logic [7:0] rx_data;
    logic tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_complete;

    uart #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clk), .reset(rst), .UART_RX(UART_RX), .UART_TX(UART_TX),
        .rx_complete(rx_complete), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_complete(tx_complete)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int rx_pulses = 0;
    int tx_pulses = 0;
    int exp_pulses = 0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] tx_q[$];

    always @(posedge clk) begin
        if (rx_complete) rx_pulses++;
        if (tx_complete) tx_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // line level k cycles after the start bit begins
    function automatic logic tx_bit(input logic [7:0] b, input int k);
        if (k < CPB) return 1'b0;
        if (k < 9 * CPB) return b[(k - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic tx_run();
        int n;
        int len;
        logic [7:0] b;
        n = tx_q.size();
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = tx_q[0];
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            b = tx_q[i];
            len = (i == n - 1) ? 10 * CPB + 4 : 10 * CPB + 2;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                check("tx_line", {UART_TX, tx_complete}, {tx_bit(b, k), k == 10 * CPB});
                if (k == 10 * CPB) begin
                    if (i == n - 1) tx_valid = 1'b0;
                    else tx_data = tx_q[i + 1];
                end
            end
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            UART_RX = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    task automatic rx_idle(input int n);
        @(negedge clk);
        UART_RX = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic rx_expect(input logic good, input logic [7:0] b);
        if (good) begin
            exp_pulses++;
            exp_data = b;
        end
        check("rx_pulses", rx_pulses, exp_pulses);
        check("rx_data", rx_data, exp_data);
    endtask

    initial begin
        int p;
        logic [7:0] b;
        logic good;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", UART_TX, 1'b1);
        check("rst_txc", tx_complete, 1'b0);
        check("rst_rxc", rx_complete, 1'b0);
        check("rst_rxd", rx_data, 8'h00);

        tx_q = {8'h55};
        tx_run();
        tx_q = {8'h41, 8'h42};
        tx_run();
        check("tx_pulses", tx_pulses, 3);

        rx_frame(8'hA3, 1'b1);
        rx_expect(1'b1, 8'hA3);
        rx_frame(8'h0F, 1'b1);
        rx_expect(1'b1, 8'h0F);
        rx_idle(20);

        @(negedge clk);
        UART_RX = 1'b0;
        repeat (4) @(negedge clk);
        UART_RX = 1'b1;
        repeat (30) @(negedge clk);
        rx_expect(1'b0, 8'h00);

        rx_frame(8'h3C, 1'b0);
        rx_idle(20);
        rx_expect(1'b0, 8'h3C);
        rx_frame(8'h99, 1'b1);
        rx_expect(1'b1, 8'h99);
        rx_idle(20);

        tx_q = {};
        for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
        fork
            tx_run();
            for (int i = 0; i < 6; i++) begin
                b = 8'($urandom);
                good = $urandom_range(0, 3) != 0;
                rx_frame(b, good);
                rx_expect(good, b);
                rx_idle(good ? $urandom_range(1, 20) : 20);
            end
        join
        check("tx_pulses_rand", tx_pulses, 7);

        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'h3A;
        repeat (50) @(negedge clk);
        check("tx_mid", UART_TX, 1'b0);
        p = tx_pulses;
        rst = 1'b1;
        #1;
        check("rst_async_tx", UART_TX, 1'b1);
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        check("rst_rxd2", rx_data, exp_data);
        check("rst_no_txc", tx_pulses, p);
        tx_q = {8'h3A};
        tx_run();
        check("tx_pulses_after", tx_pulses, p + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
